// File: rtl/div_bcd_pkg.sv
// Shared types, segment constants and digit decoder
// for the divide-and-display controller.
package div_bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      BCD,
      SHOW
   } state_t;

   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_ZERO  = 7'h40;

   // gfedcba, active-low; anything above 9 shows a dash
   function automatic logic [6:0] bcd_to_seg(
      input logic [3:0] d
   );
      case (d)
         4'd0:    return SEG_ZERO;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/div_bcd_display_bin2bcd.sv
// Sequential double-dabble: load once, then WIDTH
// step pulses leave the packed BCD value in bcd.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic [WIDTH-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd
);

   logic [WIDTH-1:0]    sh;
   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh  <= '0;
         bcd <= '0;
      end else if (load) begin
         sh  <= bin;
         bcd <= '0;
      end else if (step) begin
         sh  <= sh << 1;
         bcd <= (4*DIGITS)'({adj, sh[WIDTH-1]});
      end
   end

endmodule

// File: rtl/div_bcd_display.sv
// Restoring divider feeding two double-dabble converters
// and registered 7-segment banks with leading-zero blanking.
module div_bcd_display
   import div_bcd_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic                  busy,
   output logic                  done,
   output logic                  dbz,
   output logic [7*DIGITS-1:0]   quo_seg,
   output logic [7*DIGITS-1:0]   rem_seg
);

   if (10**DIGITS <= 2**WIDTH - 1) begin : g_bad_digits
      $error("DIGITS too small for WIDTH");
   end

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t              state, state_n;
   logic [CW-1:0]       cnt;
   logic [WIDTH:0]      pr, pr_n;
   logic [WIDTH-1:0]    qr, qr_n, dv;
   logic [WIDTH+1:0]    trial;
   logic                ge;
   logic                upd, err;
   logic                ready, take, last;
   logic                bcd_load, bcd_step;
   logic [4*DIGITS-1:0] qbcd, rbcd;

   function automatic logic [7*DIGITS-1:0] to_segs(
      input logic [4*DIGITS-1:0] v
   );
      logic [7*DIGITS-1:0] s;
      logic                lead;
      logic [3:0]          d;
      s    = '0;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         if (BLANK_LZ != 0 && lead && d == 4'd0 && i != 0)
            s[7*i +: 7] = SEG_BLANK;
         else begin
            s[7*i +: 7] = bcd_to_seg(d);
            lead = 1'b0;
         end
      end
      return s;
   endfunction

   // one restoring step: shift in next dividend bit, try subtract
   always_comb begin
      trial = {pr, qr[WIDTH-1]};
      ge    = trial >= {2'b00, dv};
      pr_n  = (WIDTH+1)'(ge ? trial - {2'b00, dv} : trial);
      qr_n  = {qr[WIDTH-2:0], ge};
   end

   assign ready = (state == IDLE) || (state == SHOW && !upd);
   assign take  = ready && start;
   assign last  = (cnt == LAST);
   assign busy  = (state == DIV) || (state == BCD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n  = state;
      bcd_load = 1'b0;
      bcd_step = 1'b0;
      unique case (state)
         IDLE, SHOW: begin
            if (take)
               state_n = (b != '0) ? DIV : SHOW;
         end
         DIV: begin
            if (last) begin
               state_n  = BCD;
               bcd_load = 1'b1;
            end
         end
         BCD: begin
            bcd_step = 1'b1;
            if (last) state_n = SHOW;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         pr      <= '0;
         qr      <= '0;
         dv      <= '0;
         upd     <= 1'b0;
         err     <= 1'b0;
         dbz     <= 1'b0;
         done    <= 1'b0;
         quo_seg <= {DIGITS{SEG_ZERO}};
         rem_seg <= {DIGITS{SEG_ZERO}};
      end else begin
         done <= upd;
         upd  <= 1'b0;
         if (upd) begin
            if (err) begin
               quo_seg <= {DIGITS{SEG_DASH}};
               rem_seg <= {DIGITS{SEG_DASH}};
               dbz     <= 1'b1;
            end else begin
               quo_seg <= to_segs(qbcd);
               rem_seg <= to_segs(rbcd);
            end
         end
         if (take) begin
            if (b != '0) begin
               qr  <= a;
               dv  <= b;
               pr  <= '0;
               cnt <= '0;
               err <= 1'b0;
               dbz <= 1'b0;
            end else begin
               err <= 1'b1;
               upd <= 1'b1;
            end
         end else if (busy) begin
            cnt <= last ? '0 : cnt + CW'(1);
            if (state == DIV) begin
               pr <= pr_n;
               qr <= qr_n;
            end
            if (state == BCD && last) upd <= 1'b1;
         end
      end
   end

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_qbcd (
      .clk  (clk),
      .rst  (rst),
      .load (bcd_load),
      .step (bcd_step),
      .bin  (qr_n),
      .bcd  (qbcd)
   );

   bin2bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_rbcd (
      .clk  (clk),
      .rst  (rst),
      .load (bcd_load),
      .step (bcd_step),
      .bin  (pr_n[WIDTH-1:0]),
      .bcd  (rbcd)
   );

endmodule

// File: tb/tb_div_bcd_display.sv
// Directed bench: blanked and unblanked instances
// driven from the same stimulus.
module tb_div_bcd_display;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        busy, done, dbz;
   logic [20:0] quo_seg, rem_seg;
   logic        busy1, done1, dbz1;
   logic [20:0] quo1, rem1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   div_bcd_display #(
      .WIDTH(8), .DIGITS(3), .BLANK_LZ(1)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .a(a), .b(b), .busy(busy), .done(done),
      .dbz(dbz), .quo_seg(quo_seg), .rem_seg(rem_seg)
   );

   div_bcd_display #(
      .WIDTH(8), .DIGITS(3), .BLANK_LZ(0)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start),
      .a(a), .b(b), .busy(busy1), .done(done1),
      .dbz(dbz1), .quo_seg(quo1), .rem_seg(rem1)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // start pulse sampled at edge k; returns at negedge after k
   task automatic pulse(
      input logic [7:0] av,
      input logic [7:0] bv
   );
      @(negedge clk);
      a = av;
      b = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(
      input  int c0,
      output int lat,
      output int bc
   );
      int c;
      c   = c0;
      bc  = busy ? 1 : 0;
      lat = -1;
      while (c < 60 && lat < 0) begin
         @(negedge clk);
         c++;
         if (done) lat = c;
         else if (busy) bc++;
      end
   endtask

   localparam logic [6:0] BL = 7'h7F;
   localparam logic [6:0] DS = 7'h3F;
   localparam logic [6:0] Z0 = 7'h40;

   initial begin
      int lat, bc, n;
      int p[$];

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_dbz", 32'(dbz), 32'd0);
      chk("rst_quo", 32'(quo_seg), 32'({Z0, Z0, Z0}));
      chk("rst_rem", 32'(rem_seg), 32'({Z0, Z0, Z0}));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 13 / 4 = 3 r 1
      pulse(8'd13, 8'd4);
      wait_done(0, lat, bc);
      chk("t1_lat", 32'(lat), 32'd17);
      chk("t1_busy", 32'(bc), 32'd16);
      chk("t1_quo", 32'(quo_seg), 32'({BL, BL, 7'h30}));
      chk("t1_rem", 32'(rem_seg), 32'({BL, BL, 7'h79}));
      chk("t1_dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      chk("t1_done1cyc", 32'(done), 32'd0);

      // 255 / 1 = 255 r 0
      pulse(8'd255, 8'd1);
      wait_done(0, lat, bc);
      chk("t2_lat", 32'(lat), 32'd17);
      chk("t2_quo", 32'(quo_seg), 32'({7'h24, 7'h12, 7'h12}));
      chk("t2_rem", 32'(rem_seg), 32'({BL, BL, Z0}));
      chk("t2_quo_nb", 32'(quo1), 32'({7'h24, 7'h12, 7'h12}));
      chk("t2_rem_nb", 32'(rem1), 32'({Z0, Z0, Z0}));
      @(negedge clk);

      // divide by zero
      pulse(8'd7, 8'd0);
      wait_done(0, lat, bc);
      chk("t3_lat", 32'(lat), 32'd1);
      chk("t3_quo", 32'(quo_seg), 32'({DS, DS, DS}));
      chk("t3_rem", 32'(rem_seg), 32'({DS, DS, DS}));
      chk("t3_dbz", 32'(dbz), 32'd1);
      @(negedge clk);

      // 9 / 3 clears dbz on acceptance
      pulse(8'd9, 8'd3);
      @(negedge clk);
      chk("t3b_dbz", 32'(dbz), 32'd0);
      chk("t3b_hold", 32'(quo_seg), 32'({DS, DS, DS}));
      wait_done(1, lat, bc);
      chk("t3b_lat", 32'(lat), 32'd17);
      chk("t3b_quo", 32'(quo_seg), 32'({BL, BL, 7'h30}));
      chk("t3b_rem", 32'(rem_seg), 32'({BL, BL, Z0}));
      @(negedge clk);

      // 200 / 7 = 28 r 4, second start while busy ignored
      pulse(8'd200, 8'd7);
      repeat (4) @(negedge clk);
      a = 8'd1;
      b = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      lat = -1;
      for (int c = 6; c <= 45; c++) begin
         @(negedge clk);
         if (done) begin
            n++;
            if (lat < 0) lat = c;
         end
      end
      chk("t4_lat", 32'(lat), 32'd17);
      chk("t4_npulse", 32'(n), 32'd1);
      chk("t4_quo", 32'(quo_seg), 32'({BL, 7'h24, 7'h00}));
      chk("t4_rem", 32'(rem_seg), 32'({BL, BL, 7'h19}));

      // reset mid-operation
      pulse(8'd100, 8'd3);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_quo", 32'(quo_seg), 32'({Z0, Z0, Z0}));
      chk("t5_rem", 32'(rem_seg), 32'({Z0, Z0, Z0}));
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("t5_nodone", 32'(n), 32'd0);
      pulse(8'd5, 8'd9);
      wait_done(0, lat, bc);
      chk("t5b_lat", 32'(lat), 32'd17);
      chk("t5b_quo", 32'(quo_seg), 32'({BL, BL, Z0}));
      chk("t5b_rem", 32'(rem_seg), 32'({BL, BL, 7'h12}));
      @(negedge clk);

      // start held high: 50 / 5 = 10 r 0
      @(negedge clk);
      a = 8'd50;
      b = 8'd5;
      start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         if (done) p.push_back(c);
      end
      start = 1'b0;
      chk("t6_npulse", 32'(p.size()), 32'd3);
      if (p.size() >= 3) begin
         chk("t6_first", 32'(p[0]), 32'd17);
         chk("t6_gap1", 32'(p[1] - p[0]), 32'd18);
         chk("t6_gap2", 32'(p[2] - p[1]), 32'd18);
      end
      chk("t6_quo", 32'(quo_seg), 32'({BL, 7'h79, Z0}));
      chk("t6_rem", 32'(rem_seg), 32'({BL, BL, Z0}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
